// File: rtl/mem_responder_pkg.sv
// Shared constants for the processor and its memory-side responder.
package mem_responder_pkg;

  localparam int unsigned addr_width          = 32;
  localparam int unsigned data_width          = 32;
  localparam int unsigned word_bytes          = data_width / 8;
  localparam int unsigned mem_latency_default = 5;
  localparam int unsigned mem_words_default   = 4096;

endpackage

// File: rtl/mem_responder_mem_array.sv
// Single-port synchronous word RAM with a registered read port.
module mem_array #(
  parameter int unsigned words = 4096,
  parameter int unsigned aw    = 12,
  parameter int unsigned dw    = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic          re,
  input  logic          rclr,
  input  logic [aw-1:0] addr,
  input  logic [dw-1:0] wdata,
  output logic [dw-1:0] rdata
);

  logic [dw-1:0] mem_q [words];
  logic [dw-1:0] rdata_q;

  // Storage is never reset; contents survive rst_n.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[addr] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else if (rclr) begin
      rdata_q <= '0;
    end else if (re) begin
      rdata_q <= mem_q[addr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/mem_responder.sv
// Request/ack memory responder: latches one request, acks after mem_latency cycles.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int unsigned mem_latency = mem_latency_default,
  parameter int unsigned mem_words   = mem_words_default
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [addr_width-1:0] addr,
  input  logic                  rd_req,
  input  logic                  wr_req,
  input  logic [data_width-1:0] wr_data,
  output logic [data_width-1:0] rd_data,
  output logic                  ack,
  output logic                  busy
);

  localparam int unsigned cnt_w  = $clog2(mem_latency + 1);
  localparam int unsigned idx_w  = addr_width - 2;
  localparam int unsigned ram_aw = (mem_words > 1) ? $clog2(mem_words) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, ACK} state_e;

  state_e                state_q, state_d;
  logic [cnt_w-1:0]      cnt_q, cnt_d;
  logic [idx_w-1:0]      idx_q, idx_d;
  logic [data_width-1:0] wdata_q, wdata_d;
  logic                  is_wr_q, is_wr_d;
  logic                  ack_q, busy_q;
  logic                  accept_c, fire_c, in_range_c;
  logic                  ram_we_c, ram_re_c, ram_rclr_c;
  logic                  unused_addr_c;

  assign unused_addr_c = ^addr[1:0];

  // Next-state, counter and request latch; simultaneous rd+wr resolves to a write.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    wdata_d  = wdata_q;
    is_wr_d  = is_wr_q;
    accept_c = (rd_req || wr_req) && (state_q != WAIT);
    if (accept_c) begin
      idx_d   = addr[addr_width-1:2];
      wdata_d = wr_data;
      is_wr_d = wr_req;
      cnt_d   = cnt_w'(mem_latency - 1);
      state_d = (mem_latency == 1) ? ACK : WAIT;
    end else begin
      case (state_q)
        WAIT: begin
          cnt_d = cnt_q - cnt_w'(1);
          if (cnt_q == cnt_w'(1)) begin
            state_d = ACK;
          end
        end
        ACK:     state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // RAM access happens on the edge entering ACK; *_d already holds the live request.
  always_comb begin
    fire_c     = (state_d == ACK);
    in_range_c = 32'(idx_d) < mem_words;
    ram_we_c   = fire_c && is_wr_d && in_range_c && rst;
    ram_re_c   = fire_c && !is_wr_d && in_range_c;
    ram_rclr_c = fire_c && !is_wr_d && !in_range_c;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      wdata_q <= '0;
      is_wr_q <= 1'b0;
      ack_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      is_wr_q <= is_wr_d;
      ack_q   <= (state_d == ACK);
      busy_q  <= (state_d == WAIT);
    end
  end

  mem_array #(
    .words (mem_words),
    .aw    (ram_aw),
    .dw    (data_width)
  ) u_mem_array (
    .clk   (clk),
    .rst_n (rst),
    .we    (ram_we_c),
    .re    (ram_re_c),
    .rclr  (ram_rclr_c),
    .addr  (ram_aw'(idx_d)),
    .wdata (wdata_d),
    .rdata (rd_data)
  );

  assign ack  = ack_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder at latency 5 and latency 1.
module tb_mem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst5, rd5, wr5, ack5, busy5;
  logic [31:0] a5, wd5, rdd5;
  logic        rst1, rd1, wr1, ack1, busy1;
  logic [31:0] a1, wd1, rdd1;

  int vecs = 0;
  int errs = 0;

  mem_responder #(.mem_latency(5), .mem_words(4096)) dut5 (
    .clk(clk), .rst(rst5), .addr(a5), .rd_req(rd5), .wr_req(wr5),
    .wr_data(wd5), .rd_data(rdd5), .ack(ack5), .busy(busy5)
  );

  mem_responder #(.mem_latency(1), .mem_words(4096)) dut1 (
    .clk(clk), .rst(rst1), .addr(a1), .rd_req(rd1), .wr_req(wr1),
    .wr_data(wd1), .rd_data(rdd1), .ack(ack1), .busy(busy1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one request to the latency-5 instance and return in its ack cycle.
  task automatic txn5(input string tag, input logic rd, input logic wr,
                      input logic [31:0] a, input logic [31:0] d);
    rd5 = rd; wr5 = wr; a5 = a; wd5 = d;
    step();
    rd5 = 1'b0; wr5 = 1'b0;
    for (int i = 1; i < 5; i++) begin
      chk({tag, " busy"}, 32'(busy5), 32'd1);
      chk({tag, " ack"}, 32'(ack5), 32'd0);
      step();
    end
    chk({tag, " ack"}, 32'(ack5), 32'd1);
    chk({tag, " busy@ack"}, 32'(busy5), 32'd0);
  endtask

  initial begin
    logic [31:0] v1 [4];
    v1 = '{32'h0000_0010, 32'h0000_0020, 32'h0000_0030, 32'h0000_0040};
    rst5 = 1'b0; rd5 = 1'b0; wr5 = 1'b0; a5 = '0; wd5 = '0;
    rst1 = 1'b0; rd1 = 1'b0; wr1 = 1'b0; a1 = '0; wd1 = '0;
    #2;
    chk("rst5 ack", 32'(ack5), 32'd0);
    chk("rst5 busy", 32'(busy5), 32'd0);
    chk("rst5 rd_data", rdd5, 32'd0);
    chk("rst1 ack", 32'(ack1), 32'd0);
    chk("rst1 busy", 32'(busy1), 32'd0);
    chk("rst1 rd_data", rdd1, 32'd0);
    step();
    step();
    rst5 = 1'b1;
    rst1 = 1'b1;

    // Write then back-to-back read issued in the write's ack cycle.
    txn5("wr40", 1'b0, 1'b1, 32'h40, 32'hDEAD_BEEF);
    chk("wr40 rd_data held", rdd5, 32'd0);
    txn5("rd40", 1'b1, 1'b0, 32'h40, 32'h0);
    chk("rd40 data", rdd5, 32'hDEAD_BEEF);

    // Preload words 0 and 1 for the dropped-request check.
    txn5("wr0", 1'b0, 1'b1, 32'h0, 32'hA5A5_0000);
    txn5("wr4", 1'b0, 1'b1, 32'h4, 32'h1111_1111);
    rd5 = 1'b1; a5 = 32'h0;
    step();
    rd5 = 1'b0;
    chk("drop busy1", 32'(busy5), 32'd1);
    step();
    chk("drop busy2", 32'(busy5), 32'd1);
    rd5 = 1'b1; a5 = 32'h4;
    step();
    rd5 = 1'b0;
    chk("drop busy3", 32'(busy5), 32'd1);
    chk("drop ack3", 32'(ack5), 32'd0);
    step();
    chk("drop ack4", 32'(ack5), 32'd0);
    step();
    chk("drop ack5", 32'(ack5), 32'd1);
    chk("drop data", rdd5, 32'hA5A5_0000);
    for (int i = 0; i < 6; i++) begin
      step();
      chk("drop no 2nd ack", 32'(ack5), 32'd0);
      chk("drop idle busy", 32'(busy5), 32'd0);
    end

    // Simultaneous read+write acts as a write.
    txn5("rd40b", 1'b1, 1'b0, 32'h40, 32'h0);
    chk("rd40b data", rdd5, 32'hDEAD_BEEF);
    txn5("rw8", 1'b1, 1'b1, 32'h8, 32'h1234);
    chk("rw8 rd_data held", rdd5, 32'hDEAD_BEEF);
    step();
    chk("rw8 single ack", 32'(ack5), 32'd0);
    txn5("rd8", 1'b1, 1'b0, 32'h8, 32'h0);
    chk("rd8 data", rdd5, 32'h1234);

    // Out-of-range index and ignored low address bits.
    txn5("wr_oor", 1'b0, 1'b1, 32'h4000, 32'h55);
    txn5("rd_oor", 1'b1, 1'b0, 32'h4000, 32'h0);
    chk("rd_oor data", rdd5, 32'h0);
    txn5("rd0", 1'b1, 1'b0, 32'h0, 32'h0);
    chk("rd0 not aliased", rdd5, 32'hA5A5_0000);
    txn5("wr13", 1'b0, 1'b1, 32'h13, 32'h66);
    txn5("rd10", 1'b1, 1'b0, 32'h10, 32'h0);
    chk("rd10 data", rdd5, 32'h66);

    // Reset in the middle of a write abandons it.
    txn5("wr20", 1'b0, 1'b1, 32'h20, 32'h99);
    txn5("rd20", 1'b1, 1'b0, 32'h20, 32'h0);
    chk("rd20 data", rdd5, 32'h99);
    step();
    wr5 = 1'b1; a5 = 32'h20; wd5 = 32'h77;
    step();
    wr5 = 1'b0;
    step();
    chk("mid busy pre-rst", 32'(busy5), 32'd1);
    rst5 = 1'b0;
    #1;
    chk("mid rst ack", 32'(ack5), 32'd0);
    chk("mid rst busy", 32'(busy5), 32'd0);
    chk("mid rst rd_data", rdd5, 32'd0);
    step();
    rst5 = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("post rst no ack", 32'(ack5), 32'd0);
      chk("post rst busy", 32'(busy5), 32'd0);
    end
    txn5("rd20b", 1'b1, 1'b0, 32'h20, 32'h0);
    chk("rd20b pre-write value", rdd5, 32'h99);

    // Latency 1: consecutive writes then consecutive reads.
    for (int i = 0; i < 4; i++) begin
      wr1 = 1'b1; a1 = 32'(i * 4); wd1 = v1[i];
      step();
      chk("l1 wr ack", 32'(ack1), 32'd1);
      chk("l1 wr busy", 32'(busy1), 32'd0);
    end
    wr1 = 1'b0;
    chk("l1 wr rd_data held", rdd1, 32'd0);
    for (int i = 0; i < 4; i++) begin
      rd1 = 1'b1; a1 = 32'(i * 4);
      step();
      chk("l1 rd ack", 32'(ack1), 32'd1);
      chk("l1 rd busy", 32'(busy1), 32'd0);
      chk("l1 rd data", rdd1, v1[i]);
    end
    rd1 = 1'b0;
    step();
    chk("l1 idle ack", 32'(ack1), 32'd0);
    chk("l1 idle busy", 32'(busy1), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
